core_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the RV32I datapath (PC, instruction register, register file, ALU, data memory) one instruction at a time.
- Drives fetch and data-memory request/ack handshakes, the PC and IR load enables, register-file write enable and next-PC select.
- Traps on illegal opcodes, ECALL/EBREAK and memory ack timeouts.
- Counts retired instructions.

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/core_sequencer_if.sv | 22 ++
 rtl/ack_timer.sv | 34 +++
 rtl/core_sequencer.sv | 164 ++++++++++++++++
 tb/tb_core_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, FSM states and output encodings for core_sequencer
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;  // PC + 4
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;  // PC + imm (branch / JAL)
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;  // (rs1 + imm) & ~1

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;
  localparam logic [1:0] TRAP_SYSTEM  = 2'd3;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - fetch and data-memory request/ack handshake bundle
// master: sequencer side (drives requests, receives acks)
// slave : memory side (receives requests, drives acks)
interface core_sequencer_if;

  logic imem_req;  // instruction fetch request
  logic imem_ack;  // fetch data valid this cycle
  logic dmem_req;  // data memory request
  logic dmem_we;   // data request is a store
  logic dmem_ack;  // data access complete this cycle

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, dmem_ack
  );

endinterface

// File: rtl/ack_timer.sv
// rtl/ack_timer.sv - reloadable down-counter bounding a memory request's wait for ack
// clk     : clock
// clear   : synchronous clear to zero
// load    : reload to ACK_TIMEOUT-1 (held while not waiting, pulsed on ack)
// expired : counter has reached zero
module ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  output logic expired
);

  localparam int W = $clog2(ACK_TIMEOUT);
  localparam logic [W-1:0] RELOAD = W'(ACK_TIMEOUT - 1);

  logic [W-1:0] count;

  // Loaded with ACK_TIMEOUT-1 on the first waiting cycle, so it reaches
  // zero on the ACK_TIMEOUT-th consecutive cycle without an ack.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb)
// clk, reset   : clock, synchronous active-high reset
// run          : level enable, sampled in IDLE and at instruction boundaries
// opcode       : IR[6:0], valid DECODE..WB
// branch_taken : branch comparison result, valid in EXEC
// mem          : imem/dmem request/ack handshakes (master side)
// ir_en, pc_en, pc_sel, reg_write : datapath strobes
// busy, halted, trap_cause, retired : status
module core_sequencer
  import riscv_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  core_sequencer_if.master     mem,
  output logic                 ir_en,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic                 reg_write,
  output logic                 busy,
  output logic                 halted,
  output logic [1:0]           trap_cause,
  output logic [CNT_W-1:0]     retired
);

  state_t     state;
  state_t     state_d;
  logic [1:0] cause_d;
  logic       pc_en_q;      // PC update in EXEC of a branch or in WB
  logic       branch_exec;  // EXEC of a branch: pc_sel follows branch_taken live
  logic [1:0] pc_sel_q;
  logic       waiting;
  logic       ack_now;
  logic       timer_load;
  logic       timer_expired;
  logic       store_done;

  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign ack_now = ((state == S_FETCH) && mem.imem_ack) ||
                   ((state == S_MEM) && mem.dmem_ack);

  // Reloading continuously outside the wait states means every entry into
  // FETCH or MEM starts a fresh wait window.
  assign timer_load = !waiting || ack_now;

  ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .clear   (reset),
    .load    (timer_load),
    .expired (timer_expired)
  );

  always_comb begin
    state_d = state;
    cause_d = trap_cause;
    case (state)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (mem.imem_ack) begin
          state_d = S_DECODE;
        end else if (timer_expired) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!is_legal_opcode(opcode)) begin
          state_d = S_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else if (opcode == OP_SYSTEM) begin
          state_d = S_TRAP;
          cause_d = TRAP_SYSTEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_d = S_MEM;
        end else if (opcode == OP_BRANCH) begin
          state_d = run ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem.dmem_ack) begin
          if (opcode == OP_STORE) begin
            state_d = run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (timer_expired) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      S_WB: begin
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs are registered from the next state so they are valid
  // for the whole cycle the FSM spends in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mem.imem_req <= 1'b0;
      mem.dmem_req <= 1'b0;
      mem.dmem_we  <= 1'b0;
      reg_write    <= 1'b0;
      pc_en_q      <= 1'b0;
      branch_exec  <= 1'b0;
      pc_sel_q     <= PC_SEL_SEQ;
      busy         <= 1'b0;
      halted       <= 1'b0;
      trap_cause   <= TRAP_NONE;
      retired      <= '0;
    end else begin
      state        <= state_d;
      mem.imem_req <= (state_d == S_FETCH);
      mem.dmem_req <= (state_d == S_MEM);
      mem.dmem_we  <= (state_d == S_MEM) && (opcode == OP_STORE);
      reg_write    <= (state_d == S_WB);
      pc_en_q      <= (state_d == S_WB) ||
                      ((state_d == S_EXEC) && (opcode == OP_BRANCH));
      branch_exec  <= (state_d == S_EXEC) && (opcode == OP_BRANCH);
      pc_sel_q     <= (state_d != S_WB)     ? PC_SEL_SEQ    :
                      (opcode == OP_JAL)    ? PC_SEL_BRANCH :
                      (opcode == OP_JALR)   ? PC_SEL_JALR   : PC_SEL_SEQ;
      busy         <= (state_d != S_IDLE) && (state_d != S_TRAP);
      halted       <= (state_d == S_TRAP);
      trap_cause   <= cause_d;
      if (pc_en) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  // A store retires in the MEM cycle its ack arrives.
  assign store_done = mem.dmem_req && mem.dmem_we && mem.dmem_ack;
  assign ir_en      = mem.imem_req && mem.imem_ack;
  assign pc_en      = pc_en_q || store_done;
  assign pc_sel     = branch_exec ? (branch_taken ? PC_SEL_BRANCH : PC_SEL_SEQ)
                                  : pc_sel_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - self-checking bench for core_sequencer
module tb_core_sequencer;

  localparam int T  = 4;
  localparam int CW = 4;

  localparam logic [6:0] O_R      = 7'b0110011;
  localparam logic [6:0] O_IALU   = 7'b0010011;
  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;
  localparam logic [6:0] O_SYS    = 7'b1110011;

  logic [6:0] legal_ops [10];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          branch_taken = 1'b0;
  logic          ir_en, pc_en, reg_write, busy, halted;
  logic [1:0]    pc_sel, trap_cause;
  logic [CW-1:0] retired;

  core_sequencer_if bus();

  core_sequencer #(
    .ACK_TIMEOUT(T),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem          (bus),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .reg_write    (reg_write),
    .busy         (busy),
    .halted       (halted),
    .trap_cause   (trap_cause),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          imem_req;
    logic          dmem_req;
    logic          dmem_we;
    logic          ir_en;
    logic          pc_en;
    logic [1:0]    pc_sel;
    logic          reg_write;
    logic          busy;
    logic          halted;
    logic [1:0]    cause;
    logic [CW-1:0] retired;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // model state: instructions retired, sticky trap cause, halted flag
  int         cnt = 0;
  logic [1:0] cause = 2'd0;
  logic       trapped = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic legal(input logic [6:0] op);
    for (int i = 0; i < 10; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t quiet();
    exp_t e;
    e = '0;
    e.halted  = trapped;
    e.cause   = cause;
    e.retired = CW'(cnt);
    return e;
  endfunction

  function automatic exp_t active();
    exp_t e;
    e = quiet();
    e.busy = 1'b1;
    return e;
  endfunction

  // One clock cycle: inputs applied just after the edge, expectation queued
  // for the compare process which samples at the following falling edge.
  task automatic cyc(input logic rs, input logic r, input logic [6:0] op, input logic bt,
                     input logic ia, input logic da, input exp_t e);
    @(posedge clk);
    #1;
    reset        = rs;
    run          = r;
    opcode       = op;
    branch_taken = bt;
    bus.imem_ack = ia;
    bus.dmem_ack = da;
    q.push_back(e);
  endtask

  task automatic go();
    cyc(1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0, quiet());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, quiet());
  endtask

  // Halted: run high and acks asserted must change nothing.
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 7'd0, 1'b0, 1'b1, 1'b1, quiet());
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, quiet());
    cnt = 0; cause = 2'd0; trapped = 1'b0;
    cyc(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, quiet());
    cyc(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, quiet());
  endtask

  // One instruction from its first fetch cycle. fwait/mwait: cycles before
  // the ack (>= T means never). run_end is driven in MEM and at the final
  // cycle. noise drives acks in cycles where they must be ignored.
  // rst_mem >= 0 asserts reset in that MEM cycle.
  task automatic do_instr(input logic [6:0] op, input int fwait, input int mwait,
                          input logic taken, input logic run_end, input logic noise,
                          input int rst_mem);
    exp_t e;
    logic is_mem;
    logic ack;
    is_mem = (op == O_LOAD) || (op == O_STORE);
    for (int k = 0; k < 64; k++) begin
      ack = (k == fwait);
      e = active(); e.imem_req = 1'b1; e.ir_en = ack;
      cyc(1'b0, 1'b1, op, 1'b0, ack, noise, e);
      if (ack) break;
      if (k == T - 1) begin cause = 2'd2; trapped = 1'b1; return; end
    end
    cyc(1'b0, 1'b1, op, 1'b0, noise, noise, active());
    if (!legal(op))  begin cause = 2'd1; trapped = 1'b1; return; end
    if (op == O_SYS) begin cause = 2'd3; trapped = 1'b1; return; end
    if (op == O_BRANCH) begin
      e = active(); e.pc_en = 1'b1; e.pc_sel = taken ? 2'd1 : 2'd0;
      cyc(1'b0, run_end, op, taken, noise, noise, e);
      cnt++;
      return;
    end
    cyc(1'b0, 1'b1, op, taken, noise, noise, active());
    if (is_mem) begin
      for (int k = 0; k < 64; k++) begin
        ack = (k == mwait);
        e = active(); e.dmem_req = 1'b1; e.dmem_we = (op == O_STORE);
        if (k == rst_mem) begin
          cyc(1'b1, 1'b0, op, 1'b0, 1'b0, 1'b0, e);
          cnt = 0; cause = 2'd0; trapped = 1'b0;
          return;
        end
        if (ack && (op == O_STORE)) begin
          e.pc_en = 1'b1;
          cyc(1'b0, run_end, op, 1'b0, noise, 1'b1, e);
          cnt++;
          return;
        end
        cyc(1'b0, run_end, op, 1'b0, noise, ack, e);
        if (ack) break;
        if (k == T - 1) begin cause = 2'd2; trapped = 1'b1; return; end
      end
    end
    e = active(); e.reg_write = 1'b1; e.pc_en = 1'b1;
    e.pc_sel = (op == O_JAL) ? 2'd1 : (op == O_JALR) ? 2'd2 : 2'd0;
    cyc(1'b0, run_end, op, 1'b0, noise, noise, e);
    cnt++;
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("imem_req",   bus.imem_req, e.imem_req);
        chk("dmem_req",   bus.dmem_req, e.dmem_req);
        chk("dmem_we",    bus.dmem_we,  e.dmem_we);
        chk("ir_en",      ir_en,        e.ir_en);
        chk("pc_en",      pc_en,        e.pc_en);
        chk("pc_sel",     pc_sel,       e.pc_sel);
        chk("reg_write",  reg_write,    e.reg_write);
        chk("busy",       busy,         e.busy);
        chk("halted",     halted,       e.halted);
        chk("trap_cause", trap_cause,   e.cause);
        chk("retired",    retired,      e.retired);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    legal_ops[0] = O_R;      legal_ops[1] = O_IALU;  legal_ops[2] = O_LOAD;
    legal_ops[3] = O_STORE;  legal_ops[4] = O_BRANCH; legal_ops[5] = O_JAL;
    legal_ops[6] = O_JALR;   legal_ops[7] = O_LUI;   legal_ops[8] = O_AUIPC;
    legal_ops[9] = O_SYS;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;

    // reset state
    cyc(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, quiet());
    cyc(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, quiet());
    idle(2);
    chk("lit_reset_retired", retired, 0);
    chk("lit_reset_busy", busy, 0);

    // R-type, fetch ack after one wait cycle
    go();
    do_instr(O_R, 1, 0, 1'b0, 1'b0, 1'b0, -1);
    idle(1);
    chk("lit_r_retired", retired, 1);

    // LOAD with 3-cycle dmem wait, two branches, store with run dropped in MEM
    go();
    do_instr(O_LOAD,   0, 3, 1'b0, 1'b1, 1'b0, -1);
    do_instr(O_BRANCH, 0, 0, 1'b1, 1'b1, 1'b0, -1);
    do_instr(O_BRANCH, 0, 0, 1'b0, 1'b1, 1'b0, -1);
    do_instr(O_STORE,  0, 1, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    chk("lit_store_retired", retired, 5);
    chk("lit_store_idle_busy", busy, 0);

    // remaining opcodes back to back, with stray acks outside FETCH/MEM
    go();
    do_instr(O_IALU,  0, 0, 1'b0, 1'b1, 1'b1, -1);
    do_instr(O_JAL,   0, 0, 1'b0, 1'b1, 1'b1, -1);
    do_instr(O_JALR,  2, 0, 1'b0, 1'b1, 1'b1, -1);
    do_instr(O_LUI,   0, 0, 1'b0, 1'b1, 1'b1, -1);
    do_instr(O_AUIPC, 0, 0, 1'b0, 1'b0, 1'b1, -1);
    idle(1);

    // ack on the last allowed fetch cycle: no trap
    go();
    do_instr(O_R, T - 1, 0, 1'b0, 1'b0, 1'b0, -1);
    idle(1);
    chk("lit_late_ack_halted", halted, 0);
    chk("lit_late_ack_retired", retired, 11);

    // counter wraps at 2^CW
    go();
    for (int i = 0; i < 5; i++) do_instr(O_R, 0, 0, 1'b0, 1'b1, 1'b0, -1);
    do_instr(O_R, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    idle(1);
    chk("lit_wrap_retired", retired, 1);

    // fetch timeout
    go();
    do_instr(O_R, 99, 0, 1'b0, 1'b1, 1'b0, -1);
    hold(3);
    chk("lit_fto_cause", trap_cause, 2);
    chk("lit_fto_halted", halted, 1);
    chk("lit_fto_imem_req", bus.imem_req, 0);
    chk("lit_fto_retired", retired, 1);
    do_reset();

    // illegal opcode
    go();
    do_instr(7'b0000000, 0, 0, 1'b0, 1'b1, 1'b0, -1);
    hold(3);
    chk("lit_ill_cause", trap_cause, 1);
    do_reset();
    chk("lit_ill_cleared", trap_cause, 0);

    // ECALL after one retired instruction
    go();
    do_instr(O_R,   0, 0, 1'b0, 1'b1, 1'b0, -1);
    do_instr(O_SYS, 0, 0, 1'b0, 1'b1, 1'b0, -1);
    hold(2);
    chk("lit_sys_cause", trap_cause, 3);
    chk("lit_sys_retired", retired, 1);
    do_reset();

    // data memory timeout on a load
    go();
    do_instr(O_LOAD, 0, 99, 1'b0, 1'b1, 1'b0, -1);
    hold(2);
    chk("lit_dto_cause", trap_cause, 2);
    do_reset();

    // reset in the middle of a store's MEM wait
    go();
    do_instr(O_R,     0, 0, 1'b0, 1'b1, 1'b0, -1);
    do_instr(O_STORE, 0, 5, 1'b0, 1'b1, 1'b0, 1);
    idle(2);
    chk("lit_mrst_dmem_req", bus.dmem_req, 0);
    chk("lit_mrst_retired", retired, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
